fp_op_initiator: RTL
====================

Name: fp_op_initiator

Overview:
- Initiator (master) end of the stb/ack operand handshake used by the team's single-precision float operator cores (divider, and any core with the same a/b/z port set).
- Accepts operand pairs plus a tag from a host-side valid/ready stream.
- Drives operand A, then operand B, into the core, then collects Z.
- Buffers results in a small FIFO for the host, and runs a watchdog that resets a hung core.

Parameters:
- TAG_W, 4, width of the command/result tag.
- RES_DEPTH, 4, result FIFO depth; power of 2, at least 2.
- TIMEOUT_CYCLES, 256, maximum number of cycles from command accept to Z transfer.
- CORE_RST_CYCLES, 2, number of cycles core_rst_n is held low on recovery.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- cmd_a  in  32  operand A (IEEE-754 single).
- cmd_b  in  32  operand B.
- cmd_tag  in  TAG_W  command tag.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  block can accept a command.
- res_z  out  32  result at the FIFO head.
- res_tag  out  TAG_W  tag of the head result.
- res_timeout  out  1  head result was produced by the watchdog.
- res_valid  out  1  FIFO not empty.
- res_ready  in  1  host pops the head.
- core_a  out  32  operand A to the core.
- core_a_stb  out  1  operand A strobe.
- core_a_ack  in  1  core ready for A.
- core_b  out  32  operand B to the core.
- core_b_stb  out  1  operand B strobe.
- core_b_ack  in  1  core ready for B.
- core_z  in  32  core result.
- core_z_stb  in  1  core result strobe.
- core_z_ack  out  1  block ready for the result.
- core_rst_n  out  1  active-low reset to the core (registered).
- busy  out  1  state is not IDLE.

Behaviour:
- Transfer rule: a word transfers on a rising edge where its stb and ack are both 1. The sender holds stb and data stable until that edge, then drops stb on that same edge. All block-driven stb/ack signals are registered.
- States: IDLE, SEND_A, SEND_B, WAIT_Z, RECOVER.
- Reset (rst=0, async):
  - state=RECOVER, recovery counter=CORE_RST_CYCLES, core_rst_n=0.
  - core_a_stb=0, core_b_stb=0, core_z_ack=0, core_a=0, core_b=0.
  - FIFO emptied: res_valid=0, res_z=0, res_tag=0, res_timeout=0.
  - cmd_ready=0, busy=1.
  - After rst releases, core_rst_n stays 0 for CORE_RST_CYCLES clocks, then goes 1; state moves to IDLE.
- cmd_ready: combinational, equal to (state==IDLE) && (fifo_count < RES_DEPTH).
- IDLE: on cmd_valid&&cmd_ready, latch a/b/tag, set core_a=cmd_a, core_a_stb<=1, watchdog<=0, go to SEND_A.
- SEND_A: on the edge where core_a_ack=1, core_a_stb<=0, core_b<=latched b, core_b_stb<=1, go to SEND_B.
- SEND_B: on the edge where core_b_ack=1, core_b_stb<=0, core_z_ack<=1, go to WAIT_Z.
- WAIT_Z: on the edge where core_z_stb=1, push {tag, core_z, timeout=0} into the FIFO, core_z_ack<=0, go to IDLE.
- Minimum latency from command accept to FIFO push is 3 edges plus core latency. A pushed result is visible on res_* the cycle after the push.
- Watchdog:
  - Increments every cycle in SEND_A, SEND_B and WAIT_Z.
  - Fires when it equals TIMEOUT_CYCLES-1 and no transfer occurs on that edge. A transfer on the same edge wins.
  - On firing: push {tag, 32'h7FC00000, timeout=1}; clear all stb/ack; core_rst_n<=0 for CORE_RST_CYCLES cycles; go to RECOVER, then IDLE.
- Push space is guaranteed because a command is accepted only when fifo_count < RES_DEPTH and only one command is ever outstanding. A push therefore never overflows.
- FIFO:
  - Circular buffer with wrap-around read/write pointers and show-ahead head.
  - Pop on res_valid&&res_ready.
  - Push and pop on the same edge leaves the count unchanged.
  - A pop when empty is ignored.
- Core data words (core_a, core_b) hold their last value when the matching stb is low.
- Reset mid-operation: the in-flight command is discarded and no result is produced.

Decomposition:
- Shared package fp_hs_pkg holds:
  - FP_QNAN = 32'h7FC00000, FP_ONE = 32'h3F800000.
  - The state enum encoding.
  - A result-record typedef {tag, z, timeout}.
- Sub-module res_fifo (parameterised width/depth; show-ahead; count, full and empty outputs) is reused by later blocks.

Test Plan:
- Divider as core; cmd a=0x40C00000 (6.0), b=0x40000000 (2.0), tag=5 -> res_z=0x40400000, res_tag=5, res_timeout=0; core_a_stb and core_b_stb each high until their ack edge and never high together.
- Behavioural core holds core_a_ack=0 for 10 cycles -> core_a_stb stays 1 and core_a is stable for the whole stall; core_b_stb stays 0; B is then delivered normally.
- res_ready=0; issue 4 commands (1.0/1.0 with tags 0..3) -> 4 results 0x3F800000 queued; cmd_ready=0 for a 5th. Pop one -> 5th accepted, and results pop in tag order 0..4.
- Core never asserts core_z_stb -> exactly TIMEOUT_CYCLES after accept, result 0x7FC00000 with res_timeout=1; core_rst_n=0 for exactly 2 cycles; a following 6.0/2.0 command returns 0x40400000.
- core_z_stb rises on the exact watchdog-fire edge -> the real result is pushed with res_timeout=0 and core_rst_n stays 1.
- Assert rst mid-WAIT_Z -> immediately all stb/ack=0, res_valid=0, core_rst_n=0; no stale result after release; core_rst_n returns to 1 after 2 clocks.

Source files
------------

// File: rtl/fp_hs_pkg.sv
// Shared definitions for the stb/ack float-operator handshake blocks:
// float constants, initiator state encoding and the result record layout.
package fp_hs_pkg;

   localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
   localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
   localparam int          HS_TAG_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEND_A  = 3'd1,
      ST_SEND_B  = 3'd2,
      ST_WAIT_Z  = 3'd3,
      ST_RECOVER = 3'd4
   } hs_state_t;

   typedef struct packed {
      logic [HS_TAG_W-1:0] tag;
      logic [31:0]         z;
      logic                timeout;
   } res_rec_t;

endpackage

// File: rtl/fp_op_initiator_res_fifo.sv
// Show-ahead circular result FIFO; power-of-2 depth, pointers wrap naturally.
module res_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == {(AW+1){1'b0}});
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? {W{1'b0}} : mem[rd_ptr];

   // Pointer and occupancy tracking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {(AW+1){1'b0}};
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage write port
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fp_op_initiator.sv
// Initiator end of the a/b/z stb/ack operand handshake: sends A then B to a float
// core, collects Z into a result FIFO, and resets the core if it hangs.
module fp_op_initiator
   import fp_hs_pkg::*;
#(
   parameter int TAG_W           = 4,
   parameter int RES_DEPTH       = 4,
   parameter int TIMEOUT_CYCLES  = 256,
   parameter int CORE_RST_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      cmd_a,
   input  logic [31:0]      cmd_b,
   input  logic [TAG_W-1:0] cmd_tag,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   output logic [31:0]      res_z,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_timeout,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      core_a,
   output logic             core_a_stb,
   input  logic             core_a_ack,
   output logic [31:0]      core_b,
   output logic             core_b_stb,
   input  logic             core_b_ack,
   input  logic [31:0]      core_z,
   input  logic             core_z_stb,
   output logic             core_z_ack,
   output logic             core_rst_n,
   output logic             busy
);
   localparam int REC_W = TAG_W + 33;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RC_W  = $clog2(CORE_RST_CYCLES + 2);
   localparam int CNT_W = $clog2(RES_DEPTH) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RC_W-1:0] RC_INIT = RC_W'(CORE_RST_CYCLES);

   hs_state_t        state, state_nx;
   logic [WD_W-1:0]  wd, wd_nx;
   logic [RC_W-1:0]  rec_cnt, rec_cnt_nx;
   logic [31:0]      b_lat, b_lat_nx;
   logic [TAG_W-1:0] tag_lat, tag_lat_nx;
   logic [31:0]      core_a_nx, core_b_nx;
   logic             a_stb_nx, b_stb_nx, z_ack_nx, core_rst_n_nx;
   logic             xfer, fire, push;
   logic [REC_W-1:0] push_rec, head;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full, fifo_empty;

   assign busy      = (state != ST_IDLE);
   assign cmd_ready = (state == ST_IDLE) && !fifo_full && (fifo_count < CNT_W'(RES_DEPTH));
   assign res_valid = !fifo_empty;
   assign res_tag     = head[REC_W-1 -: TAG_W];
   assign res_z       = head[32:1];
   assign res_timeout = head[0];

   // State and core-side handshake registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_RECOVER;
         rec_cnt    <= RC_INIT;
         wd         <= {WD_W{1'b0}};
         b_lat      <= 32'h0000_0000;
         tag_lat    <= {TAG_W{1'b0}};
         core_a     <= 32'h0000_0000;
         core_b     <= 32'h0000_0000;
         core_a_stb <= 1'b0;
         core_b_stb <= 1'b0;
         core_z_ack <= 1'b0;
         core_rst_n <= 1'b0;
      end else begin
         state      <= state_nx;
         rec_cnt    <= rec_cnt_nx;
         wd         <= wd_nx;
         b_lat      <= b_lat_nx;
         tag_lat    <= tag_lat_nx;
         core_a     <= core_a_nx;
         core_b     <= core_b_nx;
         core_a_stb <= a_stb_nx;
         core_b_stb <= b_stb_nx;
         core_z_ack <= z_ack_nx;
         core_rst_n <= core_rst_n_nx;
      end
   end

   // Next-state, handshake sequencing and watchdog
   always_comb begin
      state_nx      = state;
      rec_cnt_nx    = rec_cnt;
      wd_nx         = wd;
      b_lat_nx      = b_lat;
      tag_lat_nx    = tag_lat;
      core_a_nx     = core_a;
      core_b_nx     = core_b;
      a_stb_nx      = core_a_stb;
      b_stb_nx      = core_b_stb;
      z_ack_nx      = core_z_ack;
      core_rst_n_nx = core_rst_n;
      xfer          = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               b_lat_nx   = cmd_b;
               tag_lat_nx = cmd_tag;
               core_a_nx  = cmd_a;
               a_stb_nx   = 1'b1;
               wd_nx      = {WD_W{1'b0}};
               state_nx   = ST_SEND_A;
            end else begin
               wd_nx = wd;
            end
         end
         ST_SEND_A: begin
            wd_nx = wd + WD_W'(1);
            if (core_a_stb && core_a_ack) begin
               xfer      = 1'b1;
               a_stb_nx  = 1'b0;
               core_b_nx = b_lat;
               b_stb_nx  = 1'b1;
               state_nx  = ST_SEND_B;
            end else begin
               xfer = 1'b0;
            end
         end
         ST_SEND_B: begin
            wd_nx = wd + WD_W'(1);
            if (core_b_stb && core_b_ack) begin
               xfer     = 1'b1;
               b_stb_nx = 1'b0;
               z_ack_nx = 1'b1;
               state_nx = ST_WAIT_Z;
            end else begin
               xfer = 1'b0;
            end
         end
         ST_WAIT_Z: begin
            wd_nx = wd + WD_W'(1);
            if (core_z_ack && core_z_stb) begin
               xfer     = 1'b1;
               z_ack_nx = 1'b0;
               state_nx = ST_IDLE;
            end else begin
               xfer = 1'b0;
            end
         end
         ST_RECOVER: begin
            if (rec_cnt <= RC_W'(1)) begin
               rec_cnt_nx    = {RC_W{1'b0}};
               core_rst_n_nx = 1'b1;
               state_nx      = ST_IDLE;
            end else begin
               rec_cnt_nx = rec_cnt - RC_W'(1);
            end
         end
         default: begin
            a_stb_nx      = 1'b0;
            b_stb_nx      = 1'b0;
            z_ack_nx      = 1'b0;
            core_rst_n_nx = 1'b0;
            rec_cnt_nx    = RC_INIT;
            state_nx      = ST_RECOVER;
         end
      endcase

      // A transfer on the last watchdog edge beats the timeout.
      fire = ((state == ST_SEND_A) || (state == ST_SEND_B) || (state == ST_WAIT_Z))
             && (wd == WD_LAST) && !xfer;
      push_rec = {tag_lat, core_z, 1'b0};
      if (fire) begin
         push          = 1'b1;
         push_rec      = {tag_lat, FP_QNAN, 1'b1};
         a_stb_nx      = 1'b0;
         b_stb_nx      = 1'b0;
         z_ack_nx      = 1'b0;
         core_rst_n_nx = 1'b0;
         rec_cnt_nx    = RC_INIT;
         wd_nx         = {WD_W{1'b0}};
         state_nx      = ST_RECOVER;
      end else begin
         push = (state == ST_WAIT_Z) && xfer;
      end
   end

   res_fifo #(
      .W     (REC_W),
      .DEPTH (RES_DEPTH)
   ) u_res_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_rec),
      .pop       (res_ready),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule
